// File: rtl/tdm_pkg.sv
// ============================================================================
// tdm_pkg : shared constants and state encoding for the TDM demultiplexer
// Revision: 1.0
// ============================================================================
`default_nettype none

package tdm_pkg;

    localparam int N_SLOTS_DEF = 16;
    localparam int SEL_W_DEF   = 4;

    typedef enum logic {
        HUNT = 1'b0,
        SYNC = 1'b1
    } state_t;

endpackage : tdm_pkg

`default_nettype wire

// File: rtl/tdm_demux_1x16.sv
// ============================================================================
// tdm_demux_1x16 : serial-to-parallel TDM demux, 16 slots/frame, sync-framed
// Revision: 1.0
// ============================================================================
`default_nettype none

module tdm_demux_1x16
    import tdm_pkg::*;
#(
    parameter int N_SLOTS = N_SLOTS_DEF,
    parameter int SEL_W   = SEL_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               din_i,
    input  logic               din_valid_i,
    input  logic               frame_sync_i,
    output logic [N_SLOTS-1:0] dout_o,
    output logic               dout_valid_o,
    output logic [SEL_W-1:0]   slot_o,
    output logic               locked_o,
    output logic               frame_err_o
);

    localparam logic [SEL_W-1:0] C_LAST_SLOT = SEL_W'(N_SLOTS - 1);

    state_t             state_q;
    logic [SEL_W-1:0]   slot_q;
    // The last slot is merged straight into dout, so it never needs a shadow bit.
    logic [N_SLOTS-2:0] shadow_q;
    logic [N_SLOTS-1:0] dout_q;
    logic               dout_valid_q;
    logic               frame_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            slot_q       <= '0;
            shadow_q     <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            dout_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            if (din_valid_i) begin
                case (state_q)
                    HUNT: begin
                        if (frame_sync_i) begin
                            shadow_q[0] <= din_i;
                            slot_q      <= SEL_W'(1);
                            state_q     <= SYNC;
                        end
                    end
                    SYNC: begin
                        if (frame_sync_i && (slot_q != '0)) begin
                            // Early sync: drop the partial frame and restart on this bit.
                            frame_err_q <= 1'b1;
                            shadow_q    <= {{(N_SLOTS-2){1'b0}}, din_i};
                            slot_q      <= SEL_W'(1);
                        end else if (slot_q == C_LAST_SLOT) begin
                            dout_q       <= {din_i, shadow_q};
                            dout_valid_q <= 1'b1;
                            slot_q       <= '0;
                        end else begin
                            shadow_q[slot_q] <= din_i;
                            slot_q           <= slot_q + SEL_W'(1);
                        end
                    end
                    default: state_q <= HUNT;
                endcase
            end
        end
    end

    assign dout_o       = dout_q;
    assign dout_valid_o = dout_valid_q;
    assign slot_o       = slot_q;
    assign locked_o     = (state_q == SYNC);
    assign frame_err_o  = frame_err_q;

endmodule : tdm_demux_1x16

`default_nettype wire

// File: tb/tb_tdm_demux_1x16.sv
// ============================================================================
// tb_tdm_demux_1x16 : directed self-checking bench for tdm_demux_1x16
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_tdm_demux_1x16;

    logic        clk;
    logic        rst_n;
    logic        din;
    logic        din_valid;
    logic        frame_sync;
    logic [15:0] dout;
    logic        dout_valid;
    logic [3:0]  slot;
    logic        locked;
    logic        frame_err;

    int n_cmp;
    int n_err;

    tdm_demux_1x16 #(.N_SLOTS(16), .SEL_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .din_i        (din),
        .din_valid_i  (din_valid),
        .frame_sync_i (frame_sync),
        .dout_o       (dout),
        .dout_valid_o (dout_valid),
        .slot_o       (slot),
        .locked_o     (locked),
        .frame_err_o  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One beat: inputs set on the falling edge, outputs sampled 1 ns after the rising edge.
    task automatic beat(input logic d, input logic fs);
        @(negedge clk);
        din        = d;
        frame_sync = fs;
        din_valid  = 1'b1;
        @(posedge clk);
        #1;
        din_valid  = 1'b0;
        frame_sync = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [15:0] w, input bit sync, input int maxgap, input string tag);
        int g;
        for (int i = 0; i < 16; i++) begin
            beat(w[i], sync && (i == 0));
            n_cmp++;
            if (slot !== 4'((i + 1) % 16)) begin
                n_err++;
                $display("FAIL %s slot@beat%0d: got %0d expected %0d", tag, i, slot, (i + 1) % 16);
            end
            n_cmp++;
            if (dout_valid !== (i == 15)) begin
                n_err++;
                $display("FAIL %s dout_valid@beat%0d: got %b expected %b", tag, i, dout_valid, (i == 15));
            end
            n_cmp++;
            if (frame_err !== 1'b0) begin
                n_err++;
                $display("FAIL %s frame_err@beat%0d: got %b expected 0", tag, i, frame_err);
            end
            if (i == 15) begin
                n_cmp++;
                if (dout !== w) begin
                    n_err++;
                    $display("FAIL %s dout: got %h expected %h", tag, dout, w);
                end
            end
            g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
            repeat (g) begin
                idle();
                n_cmp++;
                if (slot !== 4'((i + 1) % 16) || dout_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL %s gap@beat%0d: got slot=%0d dv=%b expected slot=%0d dv=0",
                             tag, i, slot, dout_valid, (i + 1) % 16);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_cmp++;
        if ({dout, dout_valid, slot, locked, frame_err} !== 23'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got dout=%h dv=%b slot=%0d lk=%b fe=%b expected all 0",
                     dout, dout_valid, slot, locked, frame_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_hunt();
        for (int i = 0; i < 5; i++) begin
            beat(1'b1, 1'b0);
            n_cmp++;
            if (locked !== 1'b0 || slot !== 4'd0 || dout !== 16'h0000 ||
                dout_valid !== 1'b0 || frame_err !== 1'b0) begin
                n_err++;
                $display("FAIL hunt@%0d: got lk=%b slot=%0d dout=%h dv=%b fe=%b expected 0,0,0000,0,0",
                         i, locked, slot, dout, dout_valid, frame_err);
            end
        end
    endtask

    task automatic test_onehot();
        for (int k = 0; k < 16; k++) begin
            send_frame(16'h0001 << k, 1'b1, 0, $sformatf("onehot%0d", k));
            n_cmp++;
            if (locked !== 1'b1) begin
                n_err++;
                $display("FAIL onehot%0d locked: got %b expected 1", k, locked);
            end
        end
        idle();
        n_cmp++;
        if (dout_valid !== 1'b0 || dout !== 16'h8000) begin
            n_err++;
            $display("FAIL onehot_hold: got dv=%b dout=%h expected dv=0 dout=8000", dout_valid, dout);
        end
    endtask

    task automatic test_gapped();
        send_frame(16'hA5C3, 1'b1, 3, "gapped");
    endtask

    task automatic test_early_sync();
        for (int i = 0; i < 7; i++) beat(1'b1, (i == 0));
        n_cmp++;
        if (slot !== 4'd7) begin
            n_err++;
            $display("FAIL early_pre slot: got %0d expected 7", slot);
        end
        beat(1'b1, 1'b1);
        n_cmp++;
        if (frame_err !== 1'b1 || dout_valid !== 1'b0 || dout !== 16'hA5C3 ||
            slot !== 4'd1 || locked !== 1'b1) begin
            n_err++;
            $display("FAIL early_sync: got fe=%b dv=%b dout=%h slot=%0d lk=%b expected 1,0,a5c3,1,1",
                     frame_err, dout_valid, dout, slot, locked);
        end
        idle();
        n_cmp++;
        if (frame_err !== 1'b0) begin
            n_err++;
            $display("FAIL early_pulse: got fe=%b expected 0", frame_err);
        end
        // Bit 0 of 16'h8001 was carried by the sync beat; the remaining 15 follow.
        for (int i = 1; i < 16; i++) begin
            beat((i == 15), 1'b0);
            n_cmp++;
            if (dout_valid !== (i == 15) || frame_err !== 1'b0) begin
                n_err++;
                $display("FAIL early_frame@%0d: got dv=%b fe=%b expected dv=%b fe=0",
                         i, dout_valid, frame_err, (i == 15));
            end
        end
        n_cmp++;
        if (dout !== 16'h8001) begin
            n_err++;
            $display("FAIL early_dout: got %h expected 8001", dout);
        end
    endtask

    task automatic test_back_to_back();
        send_frame(16'hFFFF, 1'b0, 0, "b2b_ffff");
        send_frame(16'h0000, 1'b0, 0, "b2b_0000");
    endtask

    task automatic test_async_reset();
        send_frame(16'h5A5A, 1'b0, 0, "pre_reset");
        for (int i = 0; i < 9; i++) beat(1'b1, (i == 0));
        n_cmp++;
        if (slot !== 4'd9 || dout !== 16'h5A5A) begin
            n_err++;
            $display("FAIL areset_pre: got slot=%0d dout=%h expected 9 5a5a", slot, dout);
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({dout, dout_valid, slot, locked, frame_err} !== 23'd0) begin
            n_err++;
            $display("FAIL areset_now: got dout=%h dv=%b slot=%0d lk=%b fe=%b expected all 0",
                     dout, dout_valid, slot, locked, frame_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        beat(1'b1, 1'b0);
        n_cmp++;
        if (locked !== 1'b0 || slot !== 4'd0 || dout_valid !== 1'b0) begin
            n_err++;
            $display("FAIL areset_hunt: got lk=%b slot=%0d dv=%b expected 0,0,0", locked, slot, dout_valid);
        end
        send_frame(16'h1357, 1'b1, 0, "post_reset");
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        din        = 1'b0;
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        rst_n      = 1'b1;
        test_reset();
        test_hunt();
        test_onehot();
        test_gapped();
        test_early_sync();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_tdm_demux_1x16

`default_nettype wire

// File: doc/tdm_demux_1x16.md
Name: tdm_demux_1x16

Overview:
- Serial-to-parallel time-division demultiplexer. It is the receive-side counterpart of the 16:1 select mux: one data bit per slot arrives on a single line, and the block steers each bit to one of 16 output positions.
- A 4-bit slot counter replaces the external select. Frames are delimited by a sync marker.
- A completed 16-slot frame is presented as a parallel word with a one-cycle valid pulse.
- It sits between the serial link front end and the parallel consumer logic.

Parameters:
- N_SLOTS, 16, number of slots per frame. This is also the width of dout. Must be a power of 2 and at least 2.
- SEL_W, 4, slot counter width. Must equal log2(N_SLOTS).

Ports:
- clk  input  1  single system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  1  serial data bit for the current slot.
- din_valid  input  1  din (and frame_sync) are sampled only when this is high.
- frame_sync  input  1  marks the valid bit as slot 0 of a new frame.
- dout  output  N_SLOTS  last completed frame; bit k holds slot k.
- dout_valid  output  1  one-cycle pulse when dout is updated.
- slot  output  SEL_W  slot index that the next valid bit will fill.
- locked  output  1  high in SYNC state.
- frame_err  output  1  one-cycle pulse when a frame is aborted.

Behaviour:
- Reset values: dout=0, dout_valid=0, slot=0, locked=0, frame_err=0. Internal shadow register=0, state=HUNT. Reset takes effect immediately (async) regardless of mid-frame progress; the partial frame is lost and no dout_valid is issued.
- A beat is a cycle with din_valid=1. Cycles with din_valid=0 change nothing except clearing the pulse outputs. frame_sync is ignored when din_valid=0.
- HUNT state:
  - Beats with frame_sync=0 are discarded; slot stays 0.
  - A beat with frame_sync=1 writes din into shadow[0], sets slot=1, and moves to SYNC (locked=1 from the next cycle).
- SYNC state, beat with frame_sync=0:
  - Write din into shadow[slot], then slot <= slot+1.
  - When slot==N_SLOTS-1: dout <= {din, shadow[N_SLOTS-2:0]}. The current bit is merged directly, with no extra cycle. dout_valid=1 on the next cycle; slot wraps to 0.
  - Latency from the last bit sampled to dout/dout_valid is 1 cycle.
- SYNC state, beat with frame_sync=1 and slot==0: a normal frame start. Write shadow[0], slot <= 1, no error.
- SYNC state, beat with frame_sync=1 and slot!=0 (early sync):
  - Pulse frame_err for one cycle and discard the partial frame (shadow cleared).
  - The current bit becomes slot 0 of the new frame: slot <= 1.
  - dout is unchanged. The state stays SYNC.
- Missing sync: in SYNC, a beat at slot==0 with frame_sync=0 is accepted as slot 0 (free-running after lock). This is not an error.
- Simultaneous completion and sync cannot occur, because a sync beat is always slot 0 of a frame.
- dout holds its value between frames. Shadow bits from the previous frame are overwritten slot by slot and never leak into dout, because every slot is written before transfer.
- dout_valid and frame_err are never high in the same cycle.

Decomposition:
- Shared package tdm_pkg:
  - constants N_SLOTS_DEF=16 and SEL_W_DEF=4
  - state enum {HUNT, SYNC}
- No sub-module is needed. The slot counter and the shadow/transfer register live in one module.

Test Plan:
- Reset then HUNT: drive 5 beats with frame_sync=0 and din=1 -> locked=0, slot=0, dout=0, no pulses.
- One-hot frames: sync, then slots 0..15 with only slot k =1, for k=0..15 -> dout=16'h0001<<k, one dout_valid pulse per frame, 1 cycle after slot 15.
- Gapped input: frame 16'hA5C3 with din_valid=0 inserted randomly between beats -> dout=16'hA5C3, slot holds during gaps.
- Early sync: sync at slot 7 of a frame -> frame_err pulse, dout keeps previous 16'hA5C3. The next 16 beats carrying 16'h8001 -> dout=16'h8001.
- Back-to-back frames without sync after lock: 16'hFFFF then 16'h0000 -> two dout_valid pulses 16 beats apart, no frame_err.
- Async reset asserted at slot 9 between clock edges -> all outputs 0 immediately; state HUNT; no dout_valid.
